// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_pkg
//  Description : Shared types for the posted-write store buffer: the memory
//                side FSM state encoding, the buffered entry layout and a
//                helper that turns a word address back into a byte address.
//  Config      : STORE_BUFFER_FORWARD_EN (consumed by sb_fifo/store_buffer)
//  Revision    : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } sb_state_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
  } sb_entry_t;

  localparam int unsigned SB_WADDR_W = 30;

  function automatic logic [31:0] sb_byte_addr(input logic [SB_WADDR_W-1:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_sb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sb_fifo
//  Description : Circular store-entry storage with head/tail/count, push and
//                pop, the oldest (head) entry as output and, when forwarding
//                is enabled, a youngest-match search on a word address.
//  Config      : STORE_BUFFER_FORWARD_EN - builds the address comparators and
//                the o_hit/o_hit_data lookup result.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                i_push/i_push_entry - write entry at tail (caller ensures !full)
//                i_pop             - retire head entry (caller ensures !empty)
//                o_head_entry      - oldest entry
//                o_count/o_full/o_empty - occupancy
//                i_lookup_waddr, o_hit, o_hit_data - forwarding lookup
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push,
  input  sb_entry_t       i_push_entry,
  input  logic            i_pop,
  output sb_entry_t       o_head_entry,
  output logic [CW-1:0]   o_count,
  output logic            o_full,
  output logic            o_empty
`ifdef STORE_BUFFER_FORWARD_EN
  ,
  input  logic [29:0]     i_lookup_waddr,
  output logic            o_hit,
  output logic [31:0]     o_hit_data
`endif
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  // Pointers are exactly log2(DEPTH) bits, so natural overflow gives the
  // modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (i_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage contents are qualified by count, so they need no reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_tail] <= i_push_entry;
    end
  end

  assign o_head_entry = r_mem[r_head];
  assign o_count      = r_count;
  assign o_full       = (r_count == CW'(DEPTH));
  assign o_empty      = (r_count == '0);

`ifdef STORE_BUFFER_FORWARD_EN
  // Walk entries from oldest to youngest; a later match overwrites an
  // earlier one, so the result is the youngest store to that word.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) &&
          (r_mem[r_head + PW'(k)].waddr == i_lookup_waddr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_mem[r_head + PW'(k)].data;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Posted-write buffer between a single-cycle core data port
//                and a multi-cycle req/ack data memory. Stores retire into
//                the buffer in zero cycles and drain in program order; loads
//                are forwarded from the buffer or read from memory, bypassing
//                queued stores.
//  Config      : STORE_BUFFER_FORWARD_EN - defined: loads hitting a buffered
//                store are forwarded, misses read memory immediately.
//                Undefined: every load waits for an empty buffer and an idle
//                memory FSM, then reads memory.
//  Ports       : clk, reset                  - clock, sync active-high reset
//                i_cpu_we/i_cpu_re/i_cpu_addr/i_cpu_wdata - core request
//                o_cpu_rdata/o_cpu_stall     - core response
//                o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata - memory request
//                i_mem_ack/i_mem_rdata       - memory response
//                o_sb_count                  - buffer occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_cpu_we,
  input  logic            i_cpu_re,
  input  logic [31:0]     i_cpu_addr,
  input  logic [31:0]     i_cpu_wdata,
  output logic [31:0]     o_cpu_rdata,
  output logic            o_cpu_stall,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [31:0]     o_mem_addr,
  output logic [31:0]     o_mem_wdata,
  input  logic            i_mem_ack,
  input  logic [31:0]     i_mem_rdata,
  output logic [CW-1:0]   o_sb_count
);

  sb_state_t      r_state;
  sb_state_t      w_state_next;
  logic           r_mem_req;
  logic           r_mem_we;
  logic [31:0]    r_mem_addr;
  logic [31:0]    r_mem_wdata;
  logic           w_req_next;
  logic           w_we_next;
  logic [31:0]    w_addr_next;
  logic [31:0]    w_wdata_next;

  sb_entry_t      w_head;
  sb_entry_t      w_push_entry;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [CW-1:0]  w_count;
  logic           w_push;
  logic           w_pop;
  logic           w_rd_done;
  logic           w_read_go;
  logic           w_load_stall;
  logic           w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^i_cpu_addr[1:0];

  // A store is refused whenever the buffer is full at the start of the
  // cycle, even if the head retires on the same edge.
  assign w_push       = i_cpu_we && !w_fifo_full;
  assign w_pop        = (r_state == WRITE) && i_mem_ack;
  assign w_rd_done    = (r_state == READ) && i_mem_ack;
  assign w_push_entry = '{waddr: i_cpu_addr[31:2], data: i_cpu_wdata};

`ifdef STORE_BUFFER_FORWARD_EN
  logic           w_hit;
  logic [31:0]    w_hit_data;

  sb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .i_push         (w_push),
    .i_push_entry   (w_push_entry),
    .i_pop          (w_pop),
    .o_head_entry   (w_head),
    .o_count        (w_count),
    .o_full         (w_fifo_full),
    .o_empty        (w_fifo_empty),
    .i_lookup_waddr (i_cpu_addr[31:2]),
    .o_hit          (w_hit),
    .o_hit_data     (w_hit_data)
  );

  // No match means no address hazard, so a miss may overtake queued stores.
  assign w_read_go    = i_cpu_re && !w_hit;
  assign w_load_stall = i_cpu_re && !w_hit && !w_rd_done;

  always_comb begin
    o_cpu_rdata = '0;
    if (i_cpu_re) begin
      if (w_hit) begin
        o_cpu_rdata = w_hit_data;
      end else if (w_rd_done) begin
        o_cpu_rdata = i_mem_rdata;
      end
    end
  end
`else
  sb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .i_push         (w_push),
    .i_push_entry   (w_push_entry),
    .i_pop          (w_pop),
    .o_head_entry   (w_head),
    .o_count        (w_count),
    .o_full         (w_fifo_full),
    .o_empty        (w_fifo_empty)
  );

  // Without comparators, a load is only safe once every older store has
  // reached memory.
  assign w_read_go    = i_cpu_re && w_fifo_empty;
  assign w_load_stall = i_cpu_re && !w_rd_done;

  always_comb begin
    o_cpu_rdata = '0;
    if (i_cpu_re && w_rd_done) begin
      o_cpu_rdata = i_mem_rdata;
    end
  end
`endif

  assign o_cpu_stall = (i_cpu_we && w_fifo_full) || w_load_stall;
  assign o_sb_count  = w_count;

  // Next-state and memory-side register inputs. The request registers load
  // on the same edge that leaves IDLE, so mem_req is high for exactly the
  // cycles spent in WRITE/READ and drops on the ack edge, which always
  // leaves one IDLE cycle with mem_req low.
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_mem_req;
    w_we_next    = r_mem_we;
    w_addr_next  = r_mem_addr;
    w_wdata_next = r_mem_wdata;
    case (r_state)
      IDLE: begin
        if (w_read_go) begin
          w_state_next = READ;
          w_req_next   = 1'b1;
          w_we_next    = 1'b0;
          w_addr_next  = {i_cpu_addr[31:2], 2'b00};
        end else if (!w_fifo_empty) begin
          w_state_next = WRITE;
          w_req_next   = 1'b1;
          w_we_next    = 1'b1;
          w_addr_next  = sb_byte_addr(w_head.waddr);
          w_wdata_next = w_head.data;
        end
      end
      WRITE, READ: begin
        if (i_mem_ack) begin
          w_state_next = IDLE;
          w_req_next   = 1'b0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_req   <= w_req_next;
      r_mem_we    <= w_we_next;
      r_mem_addr  <= w_addr_next;
      r_mem_wdata <= w_wdata_next;
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Self-checking bench for store_buffer. A transaction-level
//                model (store queue, architectural memory, backing memory)
//                predicts occupancy, stalls, load data and the memory
//                request sequence; directed scenarios plus random traffic.
//  Config      : STORE_BUFFER_FORWARD_EN - selects the expected load policy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           cpu_we;
  logic           cpu_re;
  logic [31:0]    cpu_addr;
  logic [31:0]    cpu_wdata;
  logic [31:0]    cpu_rdata;
  logic           cpu_stall;
  logic           mem_req;
  logic           mem_we;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic           mem_ack;
  logic [31:0]    mem_rdata;
  logic [CW-1:0]  sb_count;

  store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_cpu_we    (cpu_we),
    .i_cpu_re    (cpu_re),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_stall (cpu_stall),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata),
    .o_sb_count  (sb_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
  } st_t;

  st_t          q[$];                    // stores accepted, not yet in memory
  logic [31:0]  arch [logic [29:0]];     // value the program should observe
  logic [31:0]  mmem [logic [29:0]];     // value actually held by memory

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder controls
  int hold_cycles = 0;
  int lat_min = 0, lat_max = 2;
  int mem_wait = 0, mem_lat = 0;
  bit spurious = 1'b0;

  // previous-cycle observations
  logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_miss = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0, p_load_addr = '0;
  int          p_qs = 0;
  bit          p_reset = 1'b1;
  bit          saw_reset = 1'b0;
  bit          first_after_por = 1'b1;
  logic        last_stall = 1'b0;

  function automatic logic [31:0] init_val(input logic [29:0] w);
    return {w[15:0], 16'hC0DE} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] arch_read(input logic [29:0] w);
    return arch.exists(w) ? arch[w] : init_val(w);
  endfunction

  function automatic logic [31:0] mmem_read(input logic [29:0] w);
    return mmem.exists(w) ? mmem[w] : init_val(w);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called at the falling edge: compare outputs with the model, then apply
  // the model updates that the coming rising edge will perform.
  task automatic evaluate();
    logic        hit, miss, rd_done, wr_done;
    logic [31:0] hdata;
    int          qs;
    if (reset) begin
      saw_reset  = 1'b1;
      last_stall = 1'b0;
      return;
    end
    qs    = q.size();
    hit   = 1'b0;
    hdata = '0;
    foreach (q[i]) begin
      if (q[i].waddr == cpu_addr[31:2]) begin
        hit   = 1'b1;
        hdata = q[i].data;
      end
    end
    rd_done = mem_req && !mem_we && mem_ack;
    wr_done = mem_req && mem_we && mem_ack;

    check_eq("sb_count", 32'(sb_count), 32'(qs));

    if (first_after_por) begin
      check_eq("reset_mem_we", mem_we, 0);
      check_eq("reset_mem_addr", mem_addr, 0);
      check_eq("reset_mem_wdata", mem_wdata, 0);
      first_after_por = 1'b0;
    end

    // memory request sequencing
    if (p_reset) begin
      check_eq("req_after_reset", mem_req, 0);
    end else if (p_req && !p_ack) begin
      check_eq("req_held", mem_req, 1);
      check_eq("we_held", mem_we, p_we);
      check_eq("addr_held", mem_addr, p_addr);
      check_eq("wdata_held", mem_wdata, p_wdata);
    end else if (p_req && p_ack) begin
      check_eq("idle_after_ack", mem_req, 0);
    end else if (p_miss) begin
      check_eq("read_issue_req", mem_req, 1);
      check_eq("read_issue_we", mem_we, 0);
      check_eq("read_issue_addr", mem_addr, p_load_addr);
    end else if (p_qs > 0) begin
      check_eq("write_issue_req", mem_req, 1);
      check_eq("write_issue_we", mem_we, 1);
      check_eq("write_issue_addr", mem_addr, {q[0].waddr, 2'b00});
      check_eq("write_issue_data", mem_wdata, q[0].data);
    end else begin
      check_eq("no_req_when_idle", mem_req, 0);
    end

`ifdef STORE_BUFFER_FORWARD_EN
    miss = cpu_re && !hit;
`else
    miss = cpu_re && (qs == 0);
`endif

    // core side
    if (cpu_we) begin
      check_eq("store_stall", cpu_stall, 32'(qs == DEPTH));
      check_eq("rdata_no_load", cpu_rdata, 0);
    end else if (cpu_re) begin
`ifdef STORE_BUFFER_FORWARD_EN
      if (hit) begin
        check_eq("hit_stall", cpu_stall, 0);
        check_eq("hit_data", cpu_rdata, hdata);
      end else begin
        check_eq("miss_stall", cpu_stall, !rd_done);
      end
`else
      check_eq("load_stall", cpu_stall, !rd_done);
`endif
      if (rd_done) begin
        check_eq("read_data_pass", cpu_rdata, mem_rdata);
        check_eq("read_addr", mem_addr, {cpu_addr[31:2], 2'b00});
      end
      if (!cpu_stall) begin
        check_eq("load_value", cpu_rdata, arch_read(cpu_addr[31:2]));
      end
    end else begin
      check_eq("idle_stall", cpu_stall, 0);
      check_eq("rdata_no_load", cpu_rdata, 0);
    end
    if (rd_done) begin
      check_eq("read_has_load", cpu_re, 1);
    end

    p_req       = mem_req;
    p_ack       = mem_ack;
    p_we        = mem_we;
    p_addr      = mem_addr;
    p_wdata     = mem_wdata;
    p_miss      = miss;
    p_load_addr = {cpu_addr[31:2], 2'b00};
    p_qs        = qs;
    p_reset     = 1'b0;
    last_stall  = cpu_stall;

    if (wr_done) begin
      if (qs > 0) begin
        check_eq("drain_addr", mem_addr, {q[0].waddr, 2'b00});
        check_eq("drain_data", mem_wdata, q[0].data);
        mmem[q[0].waddr] = q[0].data;
        void'(q.pop_front());
      end else begin
        check_eq("write_while_empty", mem_we, 0);
      end
    end
    if (cpu_we && qs < DEPTH) begin
      q.push_back('{waddr: cpu_addr[31:2], data: cpu_wdata});
      arch[cpu_addr[31:2]] = cpu_wdata;
    end
  endtask

  // Called just after the rising edge: reset bookkeeping and memory model.
  task automatic post_edge();
    if (saw_reset) begin
      q.delete();
      arch      = mmem;
      saw_reset = 1'b0;
      p_reset   = 1'b1;
    end
    if (mem_req) begin
      if (hold_cycles == 0 && mem_wait >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_we ? $urandom : mmem_read(mem_addr[31:2]);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        mem_wait++;
      end
    end else begin
      mem_wait  = 0;
      mem_lat   = $urandom_range(lat_max, lat_min);
      mem_ack   = spurious && ($urandom_range(5, 0) == 0);
      mem_rdata = $urandom;
    end
    if (hold_cycles > 0) hold_cycles--;
  endtask

  task automatic cycle();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
    post_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_op(input bit we, input bit re, input logic [31:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = data;
    do begin
      cycle();
      n++;
    end while (last_stall && n < 300);
    if (last_stall) check_eq("op_timeout", last_stall, 0);
    cpu_we = 1'b0; cpu_re = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!mem_req && n < 100) begin
      cycle();
      n++;
    end
    check_eq("wait_req", mem_req, 1);
  endtask

  initial begin
    reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    idle(2);
    reset = 1'b0;

    // single store, ack two cycles after request
    lat_min = 2; lat_max = 2;
    do_op(1, 0, 32'h10, 32'hDEADBEEF);
    idle(6);

    // fill beyond capacity with memory held off
    lat_min = 0; lat_max = 1;
    hold_cycles = 12;
    for (int i = 0; i < 5; i++) do_op(1, 0, 32'h200 + 32'(i * 4), 32'hA000 + 32'(i));
    idle(12);

    // two stores to one word then a load of it, memory held off
    spurious = 1'b1;
    hold_cycles = 10;
    do_op(1, 0, 32'h20, 32'd1);
    do_op(1, 0, 32'h20, 32'd2);
    do_op(0, 1, 32'h20, 32'h0);
    idle(8);

    // load miss while a write is in flight
    lat_min = 2; lat_max = 2;
    do_op(1, 0, 32'h20, 32'd3);
    wait_req();
    do_op(0, 1, 32'h40, 32'h0);
    idle(6);

    // ten stores, continuous draining, pointer wrap
    lat_min = 0; lat_max = 1;
    for (int i = 0; i < 10; i++) do_op(1, 0, 32'h300 + 32'(i * 4), 32'hB000 + 32'(i));
    idle(20);

    // reset while a write request is outstanding with entries queued
    hold_cycles = 1000;
    do_op(1, 0, 32'h100, 32'h111);
    do_op(1, 0, 32'h104, 32'h222);
    do_op(1, 0, 32'h108, 32'h333);
    wait_req();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    hold_cycles = 0;
    cycle();
    do_op(0, 1, 32'h104, 32'h0);
    idle(4);

    // random traffic over a small address window
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(99, 0);
      a = (32'($urandom_range(15, 0)) << 2) | 32'($urandom_range(3, 0));
      if (kind < 45)      do_op(1, 0, a, $urandom);
      else if (kind < 80) do_op(0, 1, a, 32'h0);
      else                idle(1);
      if ($urandom_range(49, 0) == 0) hold_cycles = $urandom_range(8, 1);
    end

    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
        cycle();
        n++;
      end
      idle(3);
      check_eq("final_drain", 32'(sb_count), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the single-cycle core's data port and a multi-cycle data memory with a req/ack handshake.
- Stores retire to the buffer in zero cycles and drain to memory in program order.
- Loads are served by forwarding from the buffer, or by a memory read that bypasses queued stores.
- The core is stalled only on a full buffer or a load that goes to memory.

Parameters:
- DEPTH, 4, number of buffered store entries; power of two, 2..16.
- CW, 3, width of the occupancy count; equals $clog2(DEPTH)+1.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- cpu_we  in  1  store request this cycle.
- cpu_re  in  1  load request this cycle; cpu_we and cpu_re are never both high.
- cpu_addr  in  32  byte address; bits [1:0] ignored (word aligned).
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid in any cycle with cpu_re=1 and cpu_stall=0.
- cpu_stall  out  1  core must hold PC and suppress register/memory commit.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word address, with bits [1:0] = 0.
- mem_wdata  out  32  write data.
- mem_ack  in  1  transaction completes this cycle; mem_rdata valid for reads.
- mem_rdata  in  32  read data.
- sb_count  out  CW  current occupancy.

Behaviour:
- Reset (synchronous, active-high): buffer empty, head=tail=0, FSM=IDLE.
  - Outputs after reset: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0, cpu_rdata=0, sb_count=0.
- Reset mid-transaction: the in-flight request is abandoned and buffered stores are discarded. mem_req is low in the cycle after reset is sampled.
- Store acceptance:
  - cpu_we=1 with count<DEPTH: entry {addr[31:2], wdata} is written at tail on the clock edge; cpu_stall=0.
  - cpu_we=1 with count==DEPTH: cpu_stall=1 and the store is not accepted, even if mem_ack retires the head in the same cycle. It is accepted in the first cycle where count<DEPTH.
- Load hit: cpu_re=1 and addr[31:2] matches a valid entry. The youngest matching entry's data is driven combinationally on cpu_rdata; cpu_stall=0; no memory access.
- Load miss: cpu_re=1 with no match.
  - cpu_stall=1 until the read's mem_ack cycle. In that cycle cpu_stall=0 and cpu_rdata=mem_rdata combinationally.
  - A miss may bypass queued stores, because no match means no address hazard.
- FSM states: IDLE, WRITE, READ.
  - IDLE -> READ: load miss pending. A read miss has priority over draining.
  - IDLE -> WRITE: buffer not empty and no load miss.
  - WRITE -> IDLE: on mem_ack; head increments and count decrements in the same edge.
  - READ -> IDLE: on mem_ack.
  - An in-flight WRITE always completes; a load miss arriving during WRITE waits for it, with cpu_stall=1.
  - At least one IDLE cycle with mem_req=0 follows every ack.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered.
  - They are asserted in the cycle after entering WRITE or READ and held stable until mem_ack.
  - mem_ack when mem_req=0 is ignored.
- Ordering: stores drain strictly FIFO; head and tail wrap modulo DEPTH.
- Simultaneous store accept and drain ack: count is unchanged, both pointers advance.
- cpu_rdata=0 whenever cpu_re=0.

Optional Feature:
- Macro: STORE_BUFFER_FORWARD_EN.
- Defined: load hit/miss behaviour exactly as above.
- Undefined:
  - No address comparators are built.
  - Any cpu_re stalls until count==0 and FSM=IDLE; then a READ is issued. Draining continues during the stall.
  - Loads with an empty buffer take the READ path directly.

Decomposition:
- Package store_buffer_pkg holds:
  - typedef enum logic [1:0] {IDLE, WRITE, READ} sb_state_t.
  - typedef struct packed {logic [29:0] waddr; logic [31:0] data;} sb_entry_t.
- Sub-module sb_fifo: circular storage with head/tail/count, push/pop, head entry output, and a youngest-match search (match logic inside the STORE_BUFFER_FORWARD_EN guard).
- store_buffer holds the FSM, stall logic and memory-side registers.

Test Plan:
- Reset, then one store 0x10 <= 0xDEADBEEF with mem_ack 2 cycles after req:
  - cpu_stall stays 0 and sb_count goes 1 -> 0.
  - mem_req high with mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, held until ack.
- 5 back-to-back stores (DEPTH=4) with mem_ack held low:
  - Stores 1-4 are accepted and the 5th stalls.
  - Raise mem_ack: the 5th is accepted the cycle after count drops to 3, and drain order matches issue order.
- Forwarding: store 0x20 <= 1, then 0x20 <= 2, then load 0x20 with memory stalled:
  - cpu_rdata=2 in the same cycle, cpu_stall=0, no READ issued.
  - With the macro undefined: load stalls until both stores drain, then reads memory.
- Load miss: load 0x40 while WRITE to 0x20 is in flight:
  - Write completes, then READ with mem_addr=0x40.
  - In the ack cycle with mem_rdata=0x12345678: cpu_stall=0 and cpu_rdata=0x12345678.
- Wrap-around: 10 stores to distinct addresses, draining continuously:
  - Memory receives all 10 in order.
  - sb_count never exceeds 4; pointers wrap correctly.
- Reset asserted while mem_req=1 with 3 entries queued:
  - Next cycle: mem_req=0, sb_count=0, cpu_stall=0.
  - A later load to a previously queued address goes to memory.
